image_buffer: RTL and testbench

Byte-wide image store between the SPI controller FSM and the BNN core. It accepts one 8-bit write per cycle at a controller-supplied address and counts accepted bytes. When a full 28×28 binary image (98 bytes) has arrived, it reports full; the BNN then reads it through a one-cycle-latency read port. A clear request zeroes memory with a one-byte-per-cycle sweep, after which the block reports empty.

---
 rtl/image_buffer_pkg.sv | 25 ++
 rtl/image_buffer_if.sv | 35 +++
 rtl/image_buffer_ram.sv | 61 ++++++
 rtl/image_buffer.sv | 165 ++++++++++++++++
 tb/tb_image_buffer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/image_buffer_pkg.sv
// ----------------------------------------------------------------------------
// img_buf_pkg
// Shared types and constants for the image_buffer block.
//   img_buf_state_t : buffer lifecycle (clearing sweep, filling, full)
//   IMG_BYTES       : bytes in one 28x28 binary image
//   IMG_ADDR_W      : default address width of the write and read ports
//   addr_in_range() : true when an address falls inside the image
// ----------------------------------------------------------------------------
package img_buf_pkg;

    typedef enum logic [1:0] {
        S_CLEARING = 2'd0,
        S_FILL     = 2'd1,
        S_FULL     = 2'd2
    } img_buf_state_t;

    localparam int IMG_BYTES  = 98;
    localparam int IMG_ADDR_W = 7;

    // Both operands widened to 32 bits so any ADDR_W/NUM_BYTES pair compares cleanly.
    function automatic logic addr_in_range(input logic [31:0] addr, input logic [31:0] num);
        return (addr < num);
    endfunction

endpackage

// File: rtl/image_buffer_if.sv
// ----------------------------------------------------------------------------
// image_buffer_if
// Bundles the controller write port, BNN read port and status flags.
//   master : controller/BNN side (drives clear, writes and reads)
//   slave  : image_buffer side (drives ready/full/empty, rd_data, addr_error)
// ----------------------------------------------------------------------------
interface image_buffer_if
    import img_buf_pkg::*;
#(
    parameter int ADDR_W = IMG_ADDR_W
);
    logic              clear;
    logic              buffer_write_request;
    logic [7:0]        buffer_write_data;
    logic [ADDR_W-1:0] buffer_write_addr;
    logic              buffer_write_ready;
    logic              buffer_full;
    logic              buffer_empty;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              addr_error;

    modport master (
        output clear, buffer_write_request, buffer_write_data, buffer_write_addr,
        output rd_en, rd_addr,
        input  buffer_write_ready, buffer_full, buffer_empty, rd_data, addr_error
    );

    modport slave (
        input  clear, buffer_write_request, buffer_write_data, buffer_write_addr,
        input  rd_en, rd_addr,
        output buffer_write_ready, buffer_full, buffer_empty, rd_data, addr_error
    );
endinterface

// File: rtl/image_buffer_ram.sv
// ----------------------------------------------------------------------------
// img_buf_ram
// NUM_BYTES x 8 storage, one write port, one registered read port.
//   clk, rst_n      : clock, synchronous active-low reset (read register only)
//   we/waddr/wdata  : write port (sweep and fill writes are muxed by the parent)
//   re/raddr/rdata  : read port, one-cycle latency, holds when re is low,
//                     out-of-range addresses return 0x00
// A same-cycle write and read to one address returns the old byte.
// ----------------------------------------------------------------------------
module img_buf_ram
    import img_buf_pkg::*;
#(
    parameter int NUM_BYTES = IMG_BYTES,
    parameter int ADDR_W    = IMG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);
    logic [7:0] mem_q [NUM_BYTES];
    logic [7:0] rdata_d;
    logic [7:0] rdata_q;

    // Next read value: sample on re, hold otherwise.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            if (addr_in_range(32'(raddr), 32'(NUM_BYTES))) begin
                rdata_d = mem_q[raddr];
            end else begin
                rdata_d = 8'h00;
            end
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Storage array; contents are not reset, the parent's sweep zeroes them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/image_buffer.sv
// ----------------------------------------------------------------------------
// image_buffer
// Byte-wide image store between the SPI controller and the BNN core.
// After reset or clear it sweeps zeros through memory, then accepts one byte
// per cycle until NUM_BYTES have arrived and reports full.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : image_buffer_if.slave (clear, write port, read port, status)
// Optional feature: define IMG_BUF_ADDR_CHECK_EN to make addr_error a sticky
// flag for out-of-range write requests; otherwise addr_error is tied to 0.
// Out-of-range writes are dropped in both builds.
// ----------------------------------------------------------------------------
module image_buffer
    import img_buf_pkg::*;
#(
    parameter int NUM_BYTES = IMG_BYTES,
    parameter int ADDR_W    = IMG_ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    image_buffer_if.slave bus
);
    localparam int                CNT_W    = $clog2(NUM_BYTES + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BYTES - 1);

    img_buf_state_t    state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ready_q, ready_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              err_q, err_d;

    logic              wr_in_range_s;
    logic              accept_s;
    logic              ram_we_s;
    logic [ADDR_W-1:0] ram_waddr_s;
    logic [7:0]        ram_wdata_s;

    assign wr_in_range_s = addr_in_range(32'(bus.buffer_write_addr), 32'(NUM_BYTES));
    // clear wins over a same-cycle write.
    assign accept_s = (state_q == S_FILL) && bus.buffer_write_request &&
                      wr_in_range_s && !bus.clear;

    // RAM write port mux: sweep zeros while clearing, controller data while filling.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = '0;
        ram_wdata_s = 8'h00;
        if ((state_q == S_CLEARING) && !bus.clear) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = idx_q;
            ram_wdata_s = 8'h00;
        end else if (accept_s) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = bus.buffer_write_addr;
            ram_wdata_s = bus.buffer_write_data;
        end else begin
            ram_we_s    = 1'b0;
        end
    end

    // Next state, sweep index, byte count and registered status flags.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        if (bus.clear) begin
            state_d = S_CLEARING;
            idx_d   = '0;
            count_d = '0;
        end else begin
            case (state_q)
                S_CLEARING: begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_FILL;
                        idx_d   = '0;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                    end
                end
                S_FILL: begin
                    if (accept_s && (count_q != FULL_CNT)) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_q == LAST_CNT) begin
                            state_d = S_FULL;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                S_FULL: begin
                    state_d = S_FULL;
                end
                default: begin
                    state_d = S_CLEARING;
                    idx_d   = '0;
                    count_d = '0;
                end
            endcase
        end

        // Flags are computed from the next state so they line up with state_q.
        ready_d = (state_d == S_FILL);
        full_d  = (state_d == S_FULL);
        empty_d = (state_d == S_FILL) && (count_d == '0);

`ifdef IMG_BUF_ADDR_CHECK_EN
        if (bus.clear) begin
            err_d = 1'b0;
        end else if ((state_q == S_FILL) && bus.buffer_write_request && !wr_in_range_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
`else
        err_d = 1'b0;
`endif
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_CLEARING;
            idx_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            ready_q <= ready_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            err_q   <= err_d;
        end
    end

    img_buf_ram #(
        .NUM_BYTES (NUM_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we_s),
        .waddr (ram_waddr_s),
        .wdata (ram_wdata_s),
        .re    (bus.rd_en),
        .raddr (bus.rd_addr),
        .rdata (bus.rd_data)
    );

    assign bus.buffer_write_ready = ready_q;
    assign bus.buffer_full        = full_q;
    assign bus.buffer_empty       = empty_q;
    assign bus.addr_error         = err_q;

endmodule

// File: tb/tb_image_buffer.sv
// ----------------------------------------------------------------------------
// tb_image_buffer
// Self-checking bench for image_buffer. A behavioural model tracks how many
// sweep cycles remain, how many bytes were accepted and what the image holds;
// a negedge process compares every DUT output against it each cycle. Directed
// scenarios with literal expectations are followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_image_buffer;
    localparam int NUM = 98;
    localparam int AW  = 7;
`ifdef IMG_BUF_ADDR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_buffer_if #(.ADDR_W(AW)) bus ();

    image_buffer #(.NUM_BYTES(NUM), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    bit         model_live = 1'b0;
    logic [7:0] m_mem [NUM];
    bit         m_known = 1'b0;
    int         m_sweep = 0;
    int         m_count = 0;
    bit         m_err = 1'b0;
    logic [7:0] m_rd = 8'h00;
    bit         m_rd_known = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: sweep length, accepted-byte count, image contents.
    always @(posedge clk) begin
        if (!rst_n) begin
            model_live = 1'b1;
            m_rd       = 8'h00;
            m_rd_known = 1'b1;
            m_sweep    = NUM;
            m_count    = 0;
            m_err      = 1'b0;
            m_known    = 1'b0;
        end else begin
            if (bus.rd_en) begin
                if (int'(bus.rd_addr) >= NUM) begin
                    m_rd       = 8'h00;
                    m_rd_known = 1'b1;
                end else begin
                    m_rd       = m_mem[int'(bus.rd_addr)];
                    m_rd_known = m_known;
                end
            end
            if (bus.clear) begin
                m_sweep = NUM;
                m_count = 0;
                m_err   = 1'b0;
                m_known = 1'b0;
            end else if (m_sweep > 0) begin
                m_sweep--;
                if (m_sweep == 0) begin
                    for (int i = 0; i < NUM; i++) m_mem[i] = 8'h00;
                    m_known = 1'b1;
                end
            end else if (bus.buffer_write_request && (m_count < NUM)) begin
                if (int'(bus.buffer_write_addr) < NUM) begin
                    m_mem[int'(bus.buffer_write_addr)] = bus.buffer_write_data;
                    m_count++;
                end else begin
                    m_err = EXP_ERR;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_live) begin
            chk("ready", 32'(bus.buffer_write_ready), 32'(m_sweep == 0 && m_count < NUM));
            chk("full",  32'(bus.buffer_full),        32'(m_sweep == 0 && m_count == NUM));
            chk("empty", 32'(bus.buffer_empty),       32'(m_sweep == 0 && m_count == 0));
            chk("addr_error", 32'(bus.addr_error),    32'(m_err));
            if (m_rd_known) chk("rd_data", 32'(bus.rd_data), 32'(m_rd));
        end
    end

    // Apply one cycle of inputs and return at the following negedge.
    task automatic cyc(input logic req, input logic [AW-1:0] wa, input logic [7:0] wd,
                       input logic clr, input logic re, input logic [AW-1:0] ra);
        bus.buffer_write_request = req;
        bus.buffer_write_addr    = wa;
        bus.buffer_write_data    = wd;
        bus.clear                = clr;
        bus.rd_en                = re;
        bus.rd_addr              = ra;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 7'd0);
    endtask

    // Idle until write_ready, bounded; returns the number of cycles waited.
    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.buffer_write_ready && n < 300) begin
            idle();
            n++;
        end
    endtask

    int n;

    initial begin
        bus.clear = 1'b0;
        bus.buffer_write_request = 1'b0;
        bus.buffer_write_addr = '0;
        bus.buffer_write_data = 8'h00;
        bus.rd_en = 1'b0;
        bus.rd_addr = '0;

        // Reset and post-reset sweep timing
        rst_n = 1'b0;
        repeat (3) idle();
        chk("rst_rd_data", 32'(bus.rd_data), 32'h00);
        rst_n = 1'b1;
        for (int i = 1; i <= NUM; i++) begin
            chk("sweep_ready_low", 32'(bus.buffer_write_ready), 32'd0);
            chk("sweep_empty_low", 32'(bus.buffer_empty), 32'd0);
            idle();
        end
        chk("cycle99_ready", 32'(bus.buffer_write_ready), 32'd1);
        chk("cycle99_empty", 32'(bus.buffer_empty), 32'd1);
        for (int a = 0; a < NUM; a++) cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'(a));
        idle();

        // Fill the image, then probe full behaviour
        for (int k = 0; k < NUM; k++)
            cyc(1'b1, 7'(k), 8'(k) ^ 8'hA5, 1'b0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)));
        chk("full_after_98", 32'(bus.buffer_full), 32'd1);
        chk("ready_after_98", 32'(bus.buffer_write_ready), 32'd0);
        cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd5);
        chk("rd5", 32'(bus.rd_data), 32'hA0);
        cyc(1'b1, 7'd3, 8'hFF, 1'b0, 1'b0, 7'd0);
        cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd3);
        chk("write99_ignored", 32'(bus.rd_data), 32'hA6);
        chk("full_holds", 32'(bus.buffer_full), 32'd1);

        // Clear, 50 writes, clear again
        cyc(1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 7'd0);
        chk("full_drops_on_clear", 32'(bus.buffer_full), 32'd0);
        wait_ready(n);
        chk("sweep_len_clear1", 32'(n), 32'd98);
        for (int k = 0; k < 50; k++) cyc(1'b1, 7'(k), 8'($urandom), 1'b0, 1'b0, 7'd0);
        chk("empty_after_50", 32'(bus.buffer_empty), 32'd0);
        cyc(1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 7'd0);
        wait_ready(n);
        chk("sweep_len_clear2", 32'(n), 32'd98);
        chk("empty_after_sweep", 32'(bus.buffer_empty), 32'd1);
        cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd10);
        chk("rd10_zero", 32'(bus.rd_data), 32'h00);

        // Clear and write in the same cycle
        for (int k = 20; k < 23; k++) cyc(1'b1, 7'(k), 8'h55, 1'b0, 1'b0, 7'd0);
        cyc(1'b1, 7'd23, 8'h77, 1'b1, 1'b0, 7'd0);
        wait_ready(n);
        chk("sweep_len_clr_wr", 32'(n), 32'd98);
        chk("empty_clr_wr", 32'(bus.buffer_empty), 32'd1);
        cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd23);
        chk("rd23_dropped", 32'(bus.rd_data), 32'h00);

        // Out-of-range write
        cyc(1'b1, 7'd100, 8'h99, 1'b0, 1'b0, 7'd0);
        chk("addr_err_set", 32'(bus.addr_error), 32'(EXP_ERR));
        chk("oob_count_unchanged", 32'(bus.buffer_empty), 32'd1);
        repeat (3) idle();
        chk("addr_err_sticky", 32'(bus.addr_error), 32'(EXP_ERR));
        cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd100);
        chk("rd100_zero", 32'(bus.rd_data), 32'h00);
        cyc(1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 7'd0);
        chk("addr_err_cleared", 32'(bus.addr_error), 32'd0);
        wait_ready(n);

        // Reset mid-fill at count 40
        for (int k = 0; k < 40; k++) cyc(1'b1, 7'(k), 8'(k + 1), 1'b0, 1'b0, 7'd0);
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        wait_ready(n);
        chk("sweep_len_reset", 32'(n), 32'd98);
        chk("empty_after_reset", 32'(bus.buffer_empty), 32'd1);
        cyc(1'b0, 7'd0, 8'h00, 1'b0, 1'b1, 7'd39);
        chk("rd39_zero", 32'(bus.rd_data), 32'h00);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            rst_n = ($urandom_range(0, 1499) != 0);
            cyc(1'($urandom_range(0, 2) != 0),
                ($urandom_range(0, 7) == 0) ? 7'($urandom_range(98, 127)) : 7'($urandom_range(0, 97)),
                8'($urandom),
                1'($urandom_range(0, 299) == 0),
                1'($urandom_range(0, 1)),
                7'($urandom_range(0, 127)));
        end
        rst_n = 1'b1;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
